// File: rtl/codeword_detector_param.sv
// codeword_detector_param: maskable serial codeword detector with saturating match counter
`timescale 1ns/1ps
module codeword_detector_param #(
  parameter int CW_WIDTH = 12,
  parameter logic [CW_WIDTH-1:0] DEFAULT_CW = 12'b1011_1111_1111,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 cw_load,
  input  logic [CW_WIDTH-1:0]  cw_value,
  input  logic [CW_WIDTH-1:0]  cw_mask,
  input  logic                 overlap_en,
  input  logic                 clr_count,
  output logic                 seq_detect,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 count_sat,
  output logic                 armed
);
  localparam int FW = $clog2(CW_WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(CW_WIDTH);
  typedef enum logic [1:0] {EMPTY, FILL, ARMED} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW_WIDTH-2:0] hist_q, hist_d;
  logic [CW_WIDTH-1:0] win, cw_q, cw_d, mask_q, mask_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d, det_q, acc, hit, restart;
  always_comb begin
    acc = bit_valid & ~cw_load;
    win = {hist_q, bit_in};
    hist_d = acc ? win[CW_WIDTH-2:0] : hist_q;
    hit = acc && fill_q >= FULL - 1'b1 && ((win ^ cw_q) & ~mask_q) == '0;
    restart = cw_load || (hit && !overlap_en);
    cw_d = cw_load ? cw_value : cw_q;
    mask_d = cw_load ? cw_mask : mask_q;
    fill_d = restart ? '0 : acc && fill_q != FULL ? fill_q + 1'b1 : fill_q;
    state_d = restart ? EMPTY : !acc ? state_q : fill_d == FULL ? ARMED : FILL;
    cnt_d = clr_count ? CNT_WIDTH'(hit) : hit && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    sat_d = (sat_q & ~clr_count) | (&cnt_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      fill_q <= '0;
      hist_q <= '0;
      cw_q <= DEFAULT_CW;
      mask_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      det_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      hist_q <= hist_d;
      cw_q <= cw_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      det_q <= hit;
    end
  end
  assign seq_detect = det_q;
  assign match_count = cnt_q;
  assign count_sat = sat_q;
  assign armed = state_q == ARMED;
endmodule
